// File: rtl/mux4_arb_pkg.sv
// Shared types and constants for the four-way round-robin mux arbiter.
package mux4_arb_pkg;

  localparam int unsigned NUM_REQ = 4;

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;
  localparam logic [1:0] SEL_C = 2'd2;
  localparam logic [1:0] SEL_D = 2'd3;

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: first set request after ptr, wrapping, ptr itself last.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] idx,
  output logic       found
);

  logic [1:0] cand;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = ptr + k[1:0];
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving mux4to1 selects and a one-hot grant, with bounded tenure.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = $clog2(MAX_HOLD + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       s1,
  output logic       s2,
  output logic       busy
);

  state_t             state_q, state_nxt;
  logic [3:0]         gnt_q, gnt_nxt;
  logic [1:0]         sel_q, sel_nxt;
  logic [1:0]         last_q, last_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;

  logic [1:0]         idle_idx, grant_idx;
  logic               idle_found, others_found;
  logic [3:0]         req_others;
  logic               owner_req;
  logic               hold_max;

  // In GRANT the select register is the owner index, so it doubles as the RR pointer there.
  assign req_others = req & ~idx_to_onehot(sel_q);
  assign owner_req  = req[sel_q];
  assign hold_max   = (cnt_q == CNT_W'(MAX_HOLD - 1));

  rr_pick4 u_pick_idle (
    .req   (req),
    .ptr   (last_q),
    .idx   (idle_idx),
    .found (idle_found)
  );

  rr_pick4 u_pick_grant (
    .req   (req_others),
    .ptr   (sel_q),
    .idx   (grant_idx),
    .found (others_found)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      sel_q   <= SEL_A;
      last_q  <= SEL_D;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      gnt_q   <= gnt_nxt;
      sel_q   <= sel_nxt;
      last_q  <= last_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:  if (idle_found) state_nxt = ST_GRANT;
      ST_GRANT: if (!owner_req && !others_found) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt_nxt  = gnt_q;
    sel_nxt  = sel_q;
    last_nxt = last_q;
    cnt_nxt  = cnt_q;
    case (state_q)
      ST_IDLE: begin
        gnt_nxt = '0;
        if (idle_found) begin
          gnt_nxt  = idx_to_onehot(idle_idx);
          sel_nxt  = idle_idx;
          last_nxt = idle_idx;
          cnt_nxt  = '0;
        end
      end
      ST_GRANT: begin
        if (!owner_req || (others_found && hold_max)) begin
          cnt_nxt = '0;
          if (others_found) begin
            gnt_nxt  = idx_to_onehot(grant_idx);
            sel_nxt  = grant_idx;
            last_nxt = grant_idx;
          end else begin
            gnt_nxt = '0;
          end
        end else if (hold_max) begin
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end
      default: gnt_nxt = '0;
    endcase
  end

  assign gnt  = gnt_q;
  assign s1   = sel_q[1];
  assign s2   = sel_q[0];
  assign busy = |gnt_q;

endmodule
